norm1_mul_rr_sched: RTL
=======================

Name: norm1_mul_rr_sched

Overview:
- Round-robin scheduler sharing one signed 10x36 multiplier (36-bit truncated product) among NUM_REQ requesters in the norm1 (LRN) datapath.
- Each requester presents an operand pair with a valid/ready handshake. The block grants at most one request per cycle and instantiates the combinational multiplier internally.
- Each result is registered once and returned with the granted requester's index on a valid/ready result port.
- Sits between the LRN square/scale stages and the shared multiplier resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8; non-power-of-2 supported)
- ID_WIDTH, 2, width of res_id; must satisfy 2**ID_WIDTH >= NUM_REQ
- A_WIDTH, 10, signed operand A width
- B_WIDTH, 36, signed operand B width
- P_WIDTH, 36, result width (low P_WIDTH bits of the signed product)

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*A_WIDTH  packed signed operand A; requester i at bits [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  packed signed operand B, same packing
- req_ready  out  NUM_REQ  one-hot-or-zero grant; handshake completes when req_valid[i] & req_ready[i]
- res_valid  out  1  result register holds valid data
- res_data  out  P_WIDTH  signed product, truncated
- res_id  out  ID_WIDTH  index of the requester that owns res_data
- res_ready  in  1  downstream accepts the result

Behaviour:
- Reset: ap_rst_n low asynchronously clears res_valid=0, res_data=0, res_id=0, round-robin pointer ptr=0. Combinational req_ready is 0 while in reset.
- can_issue = ~res_valid | res_ready. The output register is empty, or it is drained this cycle.
- Grant (combinational): if can_issue, scan i = ptr, ptr+1, ... wrapping mod NUM_REQ; grant the first i with req_valid[i]=1.
- req_ready[i] = 1 only for the granted i, otherwise 0. req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On a grant to index g at the clock edge:
  - res_data <= low P_WIDTH bits of $signed(a_g)*$signed(b_g), computed at full A_WIDTH+B_WIDTH width and then truncated. This is modular wrap, with no saturation.
  - res_id <= g
  - res_valid <= 1
  - ptr <= (g+1) mod NUM_REQ
- No grant and res_ready=1: res_valid <= 0; res_data and res_id hold their previous values.
- No grant and res_ready=0: all result outputs hold.
- Latency: 1 cycle from handshake to res_valid.
- Throughput: 1 result/cycle while res_ready=1.
- Backpressure: while res_valid=1 and res_ready=0:
  - all req_ready=0
  - res_data and res_id are stable
  - ptr unchanged
- Simultaneous drain and issue: with res_valid=1 and res_ready=1, a new grant loads the register in the same cycle, leaving no bubble.
- No grant means ptr unchanged. A requester with a held request is served within NUM_REQ grants.
- Reset mid-transfer discards any pending result. Requester operands are not captured before a grant.

Test Plan:
- Reset: hold ap_rst_n=0 with req_valid=4'hF -> req_ready=0, res_valid=0, res_data=0, res_id=0.
- Single request: requester 2 only, a=10'h3FD (-3), b=1000, res_ready=1 -> req_ready=4'b0100 in that cycle. Next cycle: res_valid=1, res_data=36'hFFFFFF448 (-3000), res_id=2.
- Fairness: req_valid=4'hF held, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles. res_id follows the same order, with res_valid continuously 1.
- Backpressure: result pending and res_ready=0 for 3 cycles -> req_ready=0 and res_data/res_id unchanged. Then raise res_ready -> the next requester after the last grant is issued in that same cycle.
- Truncation: a=10'h200 (-512), b=36'h7FFFFFFFF -> res_data=36'h000000200. Also a=10'h1FF (511), b=36'h800000000 (-2^35) -> res_data=36'h800000000.
- Mid-op reset: pulse ap_rst_n low for less than 1 cycle during streaming -> res_valid drops immediately. After release, the first grant goes to the lowest valid index (ptr=0).

Source files
------------

// File: rtl/norm1_mul_rr_sched.sv
// Round-robin arbiter sharing one signed A x B multiplier among NUM_REQ requesters.
// Each granted product is truncated to P_WIDTH bits and registered together with its requester id.
module norm1_mul_rr_sched #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 10,
    parameter int B_WIDTH  = 36,
    parameter int P_WIDTH  = 36
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         res_valid,
    output logic [P_WIDTH-1:0]           res_data,
    output logic [ID_WIDTH-1:0]          res_id,
    input  logic                         res_ready
);

    localparam int FULL_WIDTH = A_WIDTH + B_WIDTH;

    logic                         can_issue;
    logic                         gnt_found;
    logic [ID_WIDTH-1:0]          gnt_idx;
    logic [ID_WIDTH-1:0]          cand;
    logic [ID_WIDTH-1:0]          ptr;
    logic [ID_WIDTH-1:0]          ptr_nxt;
    logic signed [A_WIDTH-1:0]    a_sel;
    logic signed [B_WIDTH-1:0]    b_sel;
    logic signed [FULL_WIDTH-1:0] prod_full;

    assign can_issue = ~res_valid | res_ready;

    // Scan from ptr with wrap-around; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        if (ap_rst_n && can_issue) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
                if (!gnt_found && req_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
            req_ready[gnt_idx] = gnt_found;
        end
    end

    always_comb begin
        a_sel     = req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
        b_sel     = req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
        // Sign-extend both operands to the full product width before multiplying.
        prod_full = FULL_WIDTH'(a_sel) * FULL_WIDTH'(b_sel);
        ptr_nxt   = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ptr       <= '0;
        end else if (gnt_found) begin
            res_valid <= 1'b1;
            res_data  <= prod_full[P_WIDTH-1:0];
            res_id    <= gnt_idx;
            ptr       <= ptr_nxt;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
